// File: rtl/uart_link_pkg.sv
// Shared definitions for the UART packet link.
// Contents:
//   flowState_e        - flow-control FSM state encoding
//   DEFAULT_XOFF_CHAR  - default flow-stop character (DC3)
//   DEFAULT_XON_CHAR   - default flow-resume character (DC1)
//   levelWidth()       - bit width needed to hold an occupancy of 0..depth
package uart_link_pkg;

  typedef enum logic [1:0] {
    FLOW_ON   = 2'd0,
    SEND_XOFF = 2'd1,
    FLOW_OFF  = 2'd2,
    SEND_XON  = 2'd3
  } flowState_e;

  localparam logic [7:0] DEFAULT_XOFF_CHAR = 8'h13;
  localparam logic [7:0] DEFAULT_XON_CHAR  = 8'h11;

  // Occupancy counters must be able to represent "completely full",
  // hence depth+1 distinct values.
  function automatic int levelWidth(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/uart_link_fifo.sv
// Synchronous word FIFO with a registered read port and an occupancy count.
// Ports:
//   clk_i      in   1   clock
//   rstN_i     in   1   asynchronous active-low reset
//   wrEn_i     in   1   push request
//   wrData_i   in   W   push data
//   rdEn_i     in   1   pop request (ignored while empty)
//   rdData_o   out  W   popped word, valid the cycle after an accepted pop
//   rdValid_o  out  1   rdData_o valid strobe
//   empty_o    out  1   no words stored
//   full_o     out  1   DEPTH words stored
//   level_o    out  LW  number of words stored
module uart_link_fifo
  import uart_link_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 128,
  parameter int LW    = levelWidth(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rstN_i,
  input  logic          wrEn_i,
  input  logic [W-1:0]  wrData_i,
  input  logic          rdEn_i,
  output logic [W-1:0]  rdData_o,
  output logic          rdValid_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [LW-1:0] level_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q;
  logic [AW-1:0] rdPtr_q;
  logic [LW-1:0] count_q;
  logic [W-1:0]  rdData_q;
  logic          rdValid_q;
  logic          doRead;
  logic          doWrite;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == LW'(DEPTH));
  assign level_o   = count_q;
  assign rdData_o  = rdData_q;
  assign rdValid_o = rdValid_q;

  // A pop in the same cycle frees a slot, so a push into a full FIFO is
  // still accepted when it coincides with a real pop.
  assign doRead  = rdEn_i && !empty_o;
  assign doWrite = wrEn_i && (!full_o || doRead);

  // Storage array is left unreset; only the pointers define its contents.
  always_ff @(posedge clk_i) begin
    if (doWrite) begin
      mem_q[wrPtr_q] <= wrData_i;
    end
  end

  // Pointers, occupancy and the registered read port.
  always_ff @(posedge clk_i or negedge rstN_i) begin
    if (!rstN_i) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      rdData_q  <= '0;
      rdValid_q <= 1'b0;
    end else begin
      rdValid_q <= doRead;
      if (doRead) begin
        rdData_q <= mem_q[rdPtr_q];
        rdPtr_q  <= (rdPtr_q == AW'(DEPTH - 1)) ? '0 : rdPtr_q + AW'(1);
      end
      if (doWrite) begin
        wrPtr_q <= (wrPtr_q == AW'(DEPTH - 1)) ? '0 : wrPtr_q + AW'(1);
      end
      if (doWrite && !doRead) begin
        count_q <= count_q + LW'(1);
      end else if (!doWrite && doRead) begin
        count_q <= count_q - LW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_packet_link.sv
// UART packet link between a byte-level UART core and a word-level host.
// RX path assembles WORD_BYTES bytes into a word, buffers words in a FIFO
// and throttles the far end with XOFF/XON; TX path serialises outbound words.
// Ports:
//   clk100        in   1   clock
//   rst_n         in   1   asynchronous active-low reset
//   rx_byte       in   8   received byte
//   rx_valid      in   1   rx_byte strobe
//   tx_byte       out  8   byte to transmit
//   tx_wr         out  1   tx_byte write strobe
//   tx_ready      in   1   UART transmitter idle
//   pkt_rd_en     in   1   pop request
//   pkt_data      out  W   popped word
//   pkt_valid     out  1   pkt_data valid
//   pkt_empty     out  1   RX FIFO empty
//   rx_level      out  LW  RX FIFO occupancy
//   tx_pkt_data   in   W   outbound word
//   tx_pkt_valid  in   1   outbound word offered
//   tx_pkt_ready  out  1   serialiser idle
//   xoff_active   out  1   XOFF sent and XON not yet sent
//   overrun       out  1   sticky: complete word dropped on a full FIFO
//   frame_err     out  1   pulse: partial word discarded by idle timeout
module uart_packet_link
  import uart_link_pkg::*;
#(
  parameter int         WORD_BYTES   = 4,
  parameter int         FIFO_DEPTH   = 128,
  parameter int         HI_MARK      = 124,
  parameter int         LO_MARK      = 64,
  parameter int         MSB_FIRST    = 1,
  parameter int         IDLE_TIMEOUT = 100000,
  parameter logic [7:0] XOFF_CHAR    = DEFAULT_XOFF_CHAR,
  parameter logic [7:0] XON_CHAR     = DEFAULT_XON_CHAR
) (
  input  logic                                clk100,
  input  logic                                rst_n,
  input  logic [7:0]                          rx_byte,
  input  logic                                rx_valid,
  output logic [7:0]                          tx_byte,
  output logic                                tx_wr,
  input  logic                                tx_ready,
  input  logic                                pkt_rd_en,
  output logic [8*WORD_BYTES-1:0]             pkt_data,
  output logic                                pkt_valid,
  output logic                                pkt_empty,
  output logic [levelWidth(FIFO_DEPTH)-1:0]   rx_level,
  input  logic [8*WORD_BYTES-1:0]             tx_pkt_data,
  input  logic                                tx_pkt_valid,
  output logic                                tx_pkt_ready,
  output logic                                xoff_active,
  output logic                                overrun,
  output logic                                frame_err
);

  localparam int         W        = 8 * WORD_BYTES;
  localparam int         LW       = levelWidth(FIFO_DEPTH);
  localparam int         TW       = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam logic [2:0] LAST_IDX = 3'(WORD_BYTES - 1);

  logic [2:0]    byteCnt_q, byteCnt_d;
  logic [W-1:0]  asmWord_q, asmWord_d;
  logic [TW-1:0] idleCnt_q, idleCnt_d;
  logic          frameErr_q, frameErr_d;
  logic          overrun_q, overrun_d;
  logic [W-1:0]  fullWord;
  int            rxLane;
  logic          lastByte, popAccept, pushEn, fifoFull, timeoutHit;

  flowState_e    flowState_q, flowState_d;
  logic          flowReq, flowIssue, canIssue, serIssue;
  logic [7:0]    flowChar;

  logic          serBusy_q, serBusy_d;
  logic          serLastPend_q, serLastPend_d;
  logic [W-1:0]  serWord_q, serWord_d;
  logic [2:0]    serCnt_q, serCnt_d;
  logic [7:0]    serByte;
  int            serLane;
  logic          txWr_q, txWr_d;
  logic [7:0]    txByte_q, txByte_d;

  uart_link_fifo #(
    .W     (W),
    .DEPTH (FIFO_DEPTH),
    .LW    (LW)
  ) rxFifo (
    .clk_i     (clk100),
    .rstN_i    (rst_n),
    .wrEn_i    (pushEn),
    .wrData_i  (fullWord),
    .rdEn_i    (pkt_rd_en),
    .rdData_o  (pkt_data),
    .rdValid_o (pkt_valid),
    .empty_o   (pkt_empty),
    .full_o    (fifoFull),
    .level_o   (rx_level)
  );

  // Byte lane for the incoming byte; the completed word (including the
  // byte arriving this cycle) is what gets pushed on the last byte.
  always_comb begin
    rxLane   = (MSB_FIRST != 0) ? (WORD_BYTES - 1 - int'(byteCnt_q)) : int'(byteCnt_q);
    fullWord = asmWord_q;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (i == rxLane) fullWord[8*i +: 8] = rx_byte;
    end
  end

  assign lastByte   = rx_valid && (byteCnt_q == LAST_IDX);
  assign popAccept  = pkt_rd_en && !pkt_empty;
  assign pushEn     = lastByte && (!fifoFull || popAccept);
  assign timeoutHit = (IDLE_TIMEOUT != 0) && !rx_valid && (byteCnt_q != '0) &&
                      (idleCnt_q == TW'(IDLE_TIMEOUT));

  // Assembler, idle timer and error flags. A new byte always wins over a
  // timeout that would expire in the same cycle.
  always_comb begin
    byteCnt_d  = byteCnt_q;
    asmWord_d  = asmWord_q;
    idleCnt_d  = idleCnt_q;
    frameErr_d = 1'b0;
    overrun_d  = overrun_q;
    if (rx_valid) begin
      idleCnt_d = '0;
      asmWord_d = fullWord;
      if (lastByte) begin
        byteCnt_d = '0;
        if (!pushEn) overrun_d = 1'b1;
      end else begin
        byteCnt_d = byteCnt_q + 3'd1;
      end
    end else if (timeoutHit) begin
      byteCnt_d  = '0;
      idleCnt_d  = '0;
      frameErr_d = 1'b1;
    end else if ((byteCnt_q != '0) && (idleCnt_q != TW'(IDLE_TIMEOUT))) begin
      idleCnt_d = idleCnt_q + TW'(1);
    end
  end

  // Flow FSM state register.
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) flowState_q <= FLOW_ON;
    else        flowState_q <= flowState_d;
  end

  // Flow FSM next state: hysteresis between HI_MARK and LO_MARK.
  always_comb begin
    flowState_d = flowState_q;
    case (flowState_q)
      FLOW_ON:   if (rx_level >= LW'(HI_MARK)) flowState_d = SEND_XOFF;
      SEND_XOFF: if (flowIssue)                flowState_d = FLOW_OFF;
      FLOW_OFF:  if (rx_level < LW'(LO_MARK))  flowState_d = SEND_XON;
      SEND_XON:  if (flowIssue)                flowState_d = FLOW_ON;
      default:                                 flowState_d = FLOW_ON;
    endcase
  end

  // Flow FSM outputs.
  always_comb begin
    flowReq     = 1'b0;
    flowChar    = XOFF_CHAR;
    xoff_active = 1'b0;
    case (flowState_q)
      SEND_XOFF: flowReq = 1'b1;
      FLOW_OFF:  xoff_active = 1'b1;
      SEND_XON: begin
        flowReq     = 1'b1;
        flowChar    = XON_CHAR;
        xoff_active = 1'b1;
      end
      default: ;
    endcase
  end

  // The UART core reports busy one cycle late, so a strobe is never issued
  // directly after another one. Flow characters take priority.
  assign canIssue  = tx_ready && !txWr_q;
  assign flowIssue = canIssue && flowReq;
  assign serIssue  = canIssue && !flowReq && serBusy_q && !serLastPend_q;

  // Serialiser and TX byte register. serLastPend delays tx_pkt_ready by one
  // cycle so it only returns after the last byte's strobe is visible.
  always_comb begin
    serLane = (MSB_FIRST != 0) ? (WORD_BYTES - 1 - int'(serCnt_q)) : int'(serCnt_q);
    serByte = '0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (i == serLane) serByte = serWord_q[8*i +: 8];
    end
    serBusy_d     = serBusy_q;
    serLastPend_d = serLastPend_q;
    serWord_d     = serWord_q;
    serCnt_d      = serCnt_q;
    txWr_d        = 1'b0;
    txByte_d      = txByte_q;
    if (flowIssue) begin
      txWr_d   = 1'b1;
      txByte_d = flowChar;
    end else if (serIssue) begin
      txWr_d   = 1'b1;
      txByte_d = serByte;
      if (serCnt_q == LAST_IDX) begin
        serCnt_d      = '0;
        serLastPend_d = 1'b1;
      end else begin
        serCnt_d = serCnt_q + 3'd1;
      end
    end
    if (serLastPend_q) begin
      serBusy_d     = 1'b0;
      serLastPend_d = 1'b0;
    end
    if (tx_pkt_valid && !serBusy_q) begin
      serBusy_d = 1'b1;
      serWord_d = tx_pkt_data;
      serCnt_d  = '0;
    end
  end

  // All datapath and control registers of the top level.
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      byteCnt_q     <= '0;
      asmWord_q     <= '0;
      idleCnt_q     <= '0;
      frameErr_q    <= 1'b0;
      overrun_q     <= 1'b0;
      serBusy_q     <= 1'b0;
      serLastPend_q <= 1'b0;
      serWord_q     <= '0;
      serCnt_q      <= '0;
      txWr_q        <= 1'b0;
      txByte_q      <= '0;
    end else begin
      byteCnt_q     <= byteCnt_d;
      asmWord_q     <= asmWord_d;
      idleCnt_q     <= idleCnt_d;
      frameErr_q    <= frameErr_d;
      overrun_q     <= overrun_d;
      serBusy_q     <= serBusy_d;
      serLastPend_q <= serLastPend_d;
      serWord_q     <= serWord_d;
      serCnt_q      <= serCnt_d;
      txWr_q        <= txWr_d;
      txByte_q      <= txByte_d;
    end
  end

  assign tx_wr        = txWr_q;
  assign tx_byte      = txByte_q;
  assign tx_pkt_ready = !serBusy_q;
  assign overrun      = overrun_q;
  assign frame_err    = frameErr_q;

endmodule

// File: tb/tb_uart_packet_link.sv
// Self-checking bench for uart_packet_link. Two instances share all inputs:
// dut (MSB_FIRST=1) and dutLsb (MSB_FIRST=0), both with a short idle timeout.
module tb_uart_packet_link;

  localparam int DEPTH = 128;

  logic        clk100 = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        tx_ready;
  logic        pkt_rd_en;
  logic [31:0] tx_pkt_data;
  logic        tx_pkt_valid;

  logic [7:0]  aTxByte, bTxByte;
  logic        aTxWr, bTxWr;
  logic [31:0] aPktData, bPktData;
  logic        aPktValid, bPktValid, aPktEmpty, bPktEmpty;
  logic [7:0]  aRxLevel, bRxLevel;
  logic        aTxPktReady, bTxPktReady, aXoff, bXoff;
  logic        aOverrun, bOverrun, aFrameErr, bFrameErr;

  int checkCount = 0;
  int failCount  = 0;
  int modelLevel = 0;
  int xoffCnt    = 0;
  int xonCnt     = 0;
  int frameErrCnt = 0;
  int serSeen    = 0;
  int xoffSerPos = -1;
  logic prevTxWr = 1'b0;

  logic [31:0] expA[$];
  logic [31:0] expB[$];
  logic [7:0]  txExpQ[$];

  uart_packet_link #(.IDLE_TIMEOUT(50), .MSB_FIRST(1)) dut (
    .clk100(clk100), .rst_n(rst_n), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .tx_byte(aTxByte), .tx_wr(aTxWr), .tx_ready(tx_ready), .pkt_rd_en(pkt_rd_en),
    .pkt_data(aPktData), .pkt_valid(aPktValid), .pkt_empty(aPktEmpty), .rx_level(aRxLevel),
    .tx_pkt_data(tx_pkt_data), .tx_pkt_valid(tx_pkt_valid), .tx_pkt_ready(aTxPktReady),
    .xoff_active(aXoff), .overrun(aOverrun), .frame_err(aFrameErr)
  );

  uart_packet_link #(.IDLE_TIMEOUT(50), .MSB_FIRST(0)) dutLsb (
    .clk100(clk100), .rst_n(rst_n), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .tx_byte(bTxByte), .tx_wr(bTxWr), .tx_ready(tx_ready), .pkt_rd_en(pkt_rd_en),
    .pkt_data(bPktData), .pkt_valid(bPktValid), .pkt_empty(bPktEmpty), .rx_level(bRxLevel),
    .tx_pkt_data(tx_pkt_data), .tx_pkt_valid(tx_pkt_valid), .tx_pkt_ready(bTxPktReady),
    .xoff_active(bXoff), .overrun(bOverrun), .frame_err(bFrameErr)
  );

  always #5 clk100 = ~clk100;

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Single point of comparison for the whole bench.
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] swapBytes(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [31:0] mkWord(input int i);
    return {8'hC5, 8'(i), 8'h5A, 8'(~i)};
  endfunction

  // Output monitor: scoreboards for popped words and transmitted bytes.
  always @(negedge clk100) begin
    if (aPktValid) begin
      checkOutput("sbA_pending", (expA.size() != 0), 1);
      if (expA.size() != 0) checkOutput("pktDataMsb", aPktData, expA.pop_front());
    end
    if (bPktValid) begin
      checkOutput("sbB_pending", (expB.size() != 0), 1);
      if (expB.size() != 0) checkOutput("pktDataLsb", bPktData, expB.pop_front());
    end
    if (aFrameErr) frameErrCnt++;
    if (aTxWr) begin
      checkOutput("txGap", prevTxWr, 0);
      if (aTxByte == 8'h13) begin
        xoffCnt++;
        xoffSerPos = serSeen;
      end else if (aTxByte == 8'h11) begin
        xonCnt++;
      end else begin
        checkOutput("txReadyLow", aTxPktReady, 0);
        checkOutput("sbTx_pending", (txExpQ.size() != 0), 1);
        if (txExpQ.size() != 0) checkOutput("txByte", aTxByte, txExpQ.pop_front());
        serSeen++;
      end
    end
    prevTxWr = aTxWr;
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk100);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(posedge clk100);
    #1;
    rx_valid = 1'b0;
  endtask

  // Records the expected outcome of a completed word in the model.
  task automatic noteWord(input logic [31:0] w, input bit popOk);
    if (modelLevel < DEPTH || popOk) begin
      expA.push_back(w);
      expB.push_back(swapBytes(w));
      if (!popOk) modelLevel++;
    end
  endtask

  task automatic applyStimulus(input logic [31:0] w, input bit popSame);
    bit popOk;
    popOk = popSame && (modelLevel > 0);
    sendByte(w[31:24]);
    sendByte(w[23:16]);
    sendByte(w[15:8]);
    pkt_rd_en = popSame;
    sendByte(w[7:0]);
    pkt_rd_en = 1'b0;
    noteWord(w, popOk);
  endtask

  task automatic popWord();
    bit expValid;
    expValid  = (modelLevel > 0);
    pkt_rd_en = 1'b1;
    @(posedge clk100);
    #1;
    pkt_rd_en = 1'b0;
    checkOutput("pktValid", aPktValid, expValid);
    if (expValid) modelLevel--;
  endtask

  task automatic startSerialiser(input logic [31:0] w);
    txExpQ.push_back(w[31:24]);
    txExpQ.push_back(w[23:16]);
    txExpQ.push_back(w[15:8]);
    txExpQ.push_back(w[7:0]);
    tx_pkt_data  = w;
    tx_pkt_valid = 1'b1;
    @(posedge clk100);
    #1;
    tx_pkt_valid = 1'b0;
    checkOutput("txPktReadyDrop", aTxPktReady, 0);
  endtask

  task automatic waitSerDone();
    int n;
    n = 0;
    while (!aTxPktReady && n < 100) begin
      @(posedge clk100);
      #1;
      n++;
    end
    checkOutput("serDone", aTxPktReady, 1);
  endtask

  task automatic checkResetState();
    checkOutput("rstTxWr", aTxWr, 0);
    checkOutput("rstTxByte", aTxByte, 0);
    checkOutput("rstPktData", aPktData, 0);
    checkOutput("rstPktValid", aPktValid, 0);
    checkOutput("rstPktEmpty", aPktEmpty, 1);
    checkOutput("rstRxLevel", aRxLevel, 0);
    checkOutput("rstTxPktReady", aTxPktReady, 1);
    checkOutput("rstXoff", aXoff, 0);
    checkOutput("rstOverrun", aOverrun, 0);
    checkOutput("rstFrameErr", aFrameErr, 0);
  endtask

  initial begin
    rst_n = 1'b0; rx_byte = '0; rx_valid = 1'b0; tx_ready = 1'b1;
    pkt_rd_en = 1'b0; tx_pkt_data = '0; tx_pkt_valid = 1'b0;
    waitCycles(3);
    checkResetState();
    rst_n = 1'b1;
    waitCycles(1);

    $display("[TB] byte assembly and pop latency");
    applyStimulus(32'h11223344, 1'b0);
    checkOutput("levelOne", aRxLevel, 1);
    checkOutput("notEmpty", aPktEmpty, 0);
    popWord();
    popWord();
    checkOutput("emptyAgain", aPktEmpty, 1);

    $display("[TB] XOFF/XON hysteresis");
    for (int i = 0; i < 123; i++) applyStimulus(mkWord(i), 1'b0);
    waitCycles(4);
    checkOutput("noXoffAt123", xoffCnt, 0);
    applyStimulus(mkWord(123), 1'b0);
    waitCycles(6);
    checkOutput("levelHi", aRxLevel, 124);
    checkOutput("xoffOnce", xoffCnt, 1);
    checkOutput("xoffActive", aXoff, 1);
    for (int i = 0; i < 60; i++) popWord();
    waitCycles(4);
    checkOutput("noXonAt64", xonCnt, 0);
    popWord();
    waitCycles(6);
    checkOutput("levelLo", aRxLevel, 63);
    checkOutput("xonOnce", xonCnt, 1);
    checkOutput("xoffCleared", aXoff, 0);

    $display("[TB] full FIFO and overrun");
    for (int i = 0; i < 65; i++) applyStimulus(mkWord(200 + i), 1'b0);
    waitCycles(4);
    checkOutput("levelFull", aRxLevel, 128);
    checkOutput("xoffTwice", xoffCnt, 2);
    applyStimulus(32'hA5A55A5A, 1'b1);
    waitCycles(2);
    checkOutput("keepOverrun", aOverrun, 0);
    checkOutput("keepLevel", aRxLevel, 128);
    applyStimulus(32'hDEADDEAD, 1'b0);
    waitCycles(2);
    checkOutput("dropOverrun", aOverrun, 1);
    checkOutput("dropLevel", aRxLevel, 128);
    for (int i = 0; i < 128; i++) popWord();
    waitCycles(6);
    checkOutput("drainedLevel", aRxLevel, 0);
    checkOutput("xonTwice", xonCnt, 2);

    $display("[TB] partial word timeout");
    sendByte(8'h77);
    sendByte(8'h88);
    waitCycles(40);
    checkOutput("noEarlyFrameErr", frameErrCnt, 0);
    waitCycles(20);
    checkOutput("frameErrOnce", frameErrCnt, 1);
    checkOutput("timeoutNoPush", aRxLevel, 0);
    applyStimulus(32'hCAFEF00D, 1'b0);
    checkOutput("cleanAfterTimeout", aRxLevel, 1);
    popWord();

    $display("[TB] serialiser");
    serSeen = 0;
    startSerialiser(32'hA1B2C3D4);
    waitSerDone();
    checkOutput("serBytes", serSeen, 4);
    checkOutput("txQEmpty", txExpQ.size(), 0);

    serSeen = 0;
    xoffSerPos = -1;
    for (int i = 0; i < 123; i++) applyStimulus(mkWord(300 + i), 1'b0);
    sendByte(8'h61);
    sendByte(8'h62);
    sendByte(8'h63);
    startSerialiser(32'h5566E7F8);
    sendByte(8'h64);
    noteWord(32'h61626364, 1'b0);
    waitSerDone();
    checkOutput("serBytesMid", serSeen, 4);
    checkOutput("xoffThird", xoffCnt, 3);
    checkOutput("xoffMidWord", (xoffSerPos >= 1 && xoffSerPos <= 3), 1);
    for (int i = 0; i < 124; i++) popWord();
    waitCycles(6);
    checkOutput("xonThird", xonCnt, 3);

    $display("[TB] reset mid-word and mid-serialisation");
    serSeen = 0;
    sendByte(8'h99);
    sendByte(8'hAA);
    startSerialiser(32'h21324354);
    waitCycles(1);
    rst_n = 1'b0;
    waitCycles(3);
    checkResetState();
    checkOutput("serAborted", (serSeen < 4), 1);
    txExpQ.delete();
    rst_n = 1'b1;
    waitCycles(1);
    checkOutput("readyAfterReset", aTxPktReady, 1);
    applyStimulus(32'hBEEF0042, 1'b0);
    checkOutput("cleanAfterReset", aRxLevel, 1);
    popWord();
    waitCycles(5);
    checkOutput("sbDrained", expA.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
